seq_serializer: RTL and testbench
=================================

Name: seq_serializer

Overview:
- Upstream stage of the serial sequence counter. Accepts parallel words through a valid/ready handshake and shifts them out one bit per clock on a serial `data` line.
- A one-entry holding register lets consecutive words stream with no idle gap between them.
- `data_valid` marks live bits and `word_done` flags the last bit of each word, so the downstream counter can gate or frame its sampling.

Parameters:
- WIDTH, 8, bits per parallel word; must be >= 2.
- LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first.
- IDLE_BIT, 0, level driven on `data` while no word is being shifted.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_word  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block can accept a word this cycle.
- data  output  1  serial bit stream; feeds the sequence counter's `data` input.
- data_valid  output  1  `data` carries a live bit this cycle.
- word_done  output  1  high during the last bit of each word.
- busy  output  1  shifter active or holding register full.

Behaviour:
- Reset (reset==0, async):
  - State = IDLE; shift register = 0; bit counter = 0; holding register empty.
  - Outputs: in_ready=1, data=IDLE_BIT, data_valid=0, word_done=0, busy=0.
  - Reset asserted mid-word aborts the word: remaining bits and the held word are discarded, and no word_done is produced.
- Handshake:
  - Accept occurs at a rising edge when in_valid && in_ready.
  - in_ready = !hold_full (combinational from register state).
  - in_word is sampled only on accept.
- States: IDLE, SHIFT.
- Loading the shifter:
  - Accept with the shifter in IDLE: the word loads directly into the shifter at that edge; state becomes SHIFT and bit_cnt = WIDTH-1.
  - Accept while shifting any bit but the last: the word goes into the holding register.
  - Accept on the edge that ends the last bit, with hold empty: the word bypasses into the shifter; no gap.
- Output timing:
  - data = shifter MSB (LSB if LSB_FIRST), driven from registers.
  - data_valid = (state==SHIFT).
  - First bit appears in the cycle after the accept edge; latency is 1 cycle.
  - A word occupies exactly WIDTH consecutive data_valid cycles.
- Shifting:
  - Each edge in SHIFT: shift by one toward the output end; bit_cnt decrements.
  - word_done = data_valid && bit_cnt==0 (combinational, one cycle per word).
- At the edge ending the last bit:
  - Hold full: load hold into the shifter, hold becomes empty, stay in SHIFT.
  - Else an accept is occurring: load the accepted word, stay in SHIFT.
  - Else go to IDLE, and data returns to IDLE_BIT.
- Hold full on the last-bit cycle: in_ready=0, so there is no accept; in_ready rises the following cycle.
- Throughput: sustained one bit per clock with no bubble between words, provided in_valid is presented before the hold drains.
- busy = (state==SHIFT) || hold_full.
- Width rules:
  - Bit counter is $clog2(WIDTH) bits.
  - Shift fills with 0.
  - No arithmetic overflow is possible (counter bounded by WIDTH-1).

Decomposition:
- Package seq_pkg:
  - State enum {IDLE, SHIFT}.
  - Default WIDTH localparam.
  - Shared bit-order constants (MSB_FIRST=0, LSB_FIRST=1).
- One natural sub-module: seq_hold_reg, a one-entry valid/data register with load/unload, async active-low reset, and `full` output.
- Shifter, counter and FSM stay in seq_serializer.

Test Plan:
- Reset release, then in_word=8'hE6 with a 1-cycle in_valid pulse.
  - data_valid high for exactly 8 cycles.
  - data = 1,1,1,0,0,1,1,0.
  - word_done only on the final 0.
  - Then data=0, busy=0.
- Back-to-back: 8'hFF then 8'h0F with in_valid held high.
  - 16 contiguous data_valid cycles: 1x8, then 0,0,0,0,1,1,1,1.
  - in_ready drops while hold is full.
  - word_done pulses at cycles 8 and 16.
- Third word presented while hold is full.
  - in_valid waits with in_ready=0; no word lost or duplicated.
  - Third word begins immediately after word 2's last bit.
- LSB_FIRST=1, in_word=8'h01.
  - data = 1 then 0 x7.
- Reset pulled low at bit 4 of 8'hAA with 8'h55 held.
  - data_valid=0 and in_ready=1 immediately (async).
  - After release no bits of either word appear.
  - A new word 8'h80 serializes cleanly.
- Chained into the sequence counter with stream 8'hE6, 8'hF0.
  - Counter output matches the golden model for the bit stream 1,1,1,0,0,1,1,0,1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// seq_pkg : shared types and constants for the serial sequence front end
// Revision: 1.0
// ============================================================================
package seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam bit BIT_MSB_FIRST = 1'b0;
    localparam bit BIT_LSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seq_hold_reg.sv
`default_nettype none
// ============================================================================
// seq_hold_reg : one-entry valid/data holding register with load/unload
// Revision: 1.0
// ============================================================================
module seq_hold_reg
    import seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] load_data,
    output logic             full,
    output logic [WIDTH-1:0] held_data
);

    // Load wins over unload; the owner never asks for both in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full      <= 1'b0;
            held_data <= '0;
        end else if (load) begin
            full      <= 1'b1;
            held_data <= load_data;
        end else if (unload) begin
            full      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// seq_serializer : parallel word to serial bit stream, gapless via hold reg
// Revision: 1.0
// ============================================================================
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter int   LSB_FIRST = 0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_nxt;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_nxt;
    logic               out_bit;
    logic               accept;
    logic               hold_full;
    logic               hold_load;
    logic               hold_unload;
    logic [WIDTH-1:0]   hold_data;

    generate
        if (LSB_FIRST == int'(BIT_LSB_FIRST)) begin : g_lsb_first
            assign shifted = {1'b0, shreg[WIDTH-1:1]};
            assign out_bit = shreg[0];
        end else begin : g_msb_first
            assign shifted = {shreg[WIDTH-2:0], 1'b0};
            assign out_bit = shreg[WIDTH-1];
        end
    endgenerate

    seq_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .unload    (hold_unload),
        .load_data (in_word),
        .full      (hold_full),
        .held_data (hold_data)
    );

    assign in_ready   = !hold_full;
    assign accept     = in_valid && in_ready;
    assign data_valid = (state == SHIFT);
    assign word_done  = data_valid && (bit_cnt == '0);
    assign data       = data_valid ? out_bit : IDLE_BIT;
    assign busy       = data_valid || hold_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt   = in_word;
                    bit_cnt_nxt = CNT_LAST;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    shreg_nxt   = shifted;
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    hold_load   = accept;
                end else if (hold_full) begin
                    // Last bit: refill from hold first, so ordering is preserved.
                    shreg_nxt   = hold_data;
                    bit_cnt_nxt = CNT_LAST;
                    hold_unload = 1'b1;
                end else if (accept) begin
                    shreg_nxt   = in_word;
                    bit_cnt_nxt = CNT_LAST;
                end else begin
                    shreg_nxt   = '0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// tb_seq_serializer : scoreboard bench, MSB-first and LSB-first instances
// Revision: 1.0
// ============================================================================
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] a_word = '0;
    logic         a_valid = 1'b0;
    logic         a_ready, a_data, a_dv, a_done, a_busy;
    logic [W-1:0] b_word = '0;
    logic         b_valid = 1'b0;
    logic         b_ready, b_data, b_dv, b_done, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected stream entries: {bit, last-bit-of-word}
    logic [1:0] qa[$];
    logic [1:0] qb[$];

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .LSB_FIRST(0), .IDLE_BIT(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .in_word(a_word), .in_valid(a_valid),
        .in_ready(a_ready), .data(a_data), .data_valid(a_dv),
        .word_done(a_done), .busy(a_busy)
    );

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1), .IDLE_BIT(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .in_word(b_word), .in_valid(b_valid),
        .in_ready(b_ready), .data(b_data), .data_valid(b_dv),
        .word_done(b_done), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference: the k-th bit in time order, derived from the word alone.
    function automatic void push_a(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) qa.push_back({w[W-1-k], k == W-1});
    endfunction

    function automatic void push_b(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) qb.push_back({w[k], k == W-1});
    endfunction

    always @(negedge clk) begin : mon_a
        int n;
        logic [1:0] e;
        if (!reset) begin
            qa.delete();
            check("a_rst_valid", 32'(a_dv), 32'd0);
            check("a_rst_ready", 32'(a_ready), 32'd1);
            check("a_rst_busy", 32'(a_busy), 32'd0);
            check("a_rst_done", 32'(a_done), 32'd0);
            check("a_rst_data", 32'(a_data), 32'd0);
        end else begin
            n = qa.size();
            check("a_valid", 32'(a_dv), 32'(n > 0));
            check("a_busy", 32'(a_busy), 32'(n > 0));
            check("a_ready", 32'(a_ready), 32'(n <= W));
            if (n > 0) begin
                e = qa.pop_front();
                check("a_data", 32'(a_data), 32'(e[1]));
                check("a_done", 32'(a_done), 32'(e[0]));
            end else begin
                check("a_idle_data", 32'(a_data), 32'd0);
                check("a_idle_done", 32'(a_done), 32'd0);
            end
            if (a_valid && a_ready) push_a(a_word);
        end
    end

    always @(negedge clk) begin : mon_b
        int n;
        logic [1:0] e;
        if (!reset) begin
            qb.delete();
            check("b_rst_valid", 32'(b_dv), 32'd0);
            check("b_rst_ready", 32'(b_ready), 32'd1);
            check("b_rst_data", 32'(b_data), 32'd1);
        end else begin
            n = qb.size();
            check("b_valid", 32'(b_dv), 32'(n > 0));
            check("b_busy", 32'(b_busy), 32'(n > 0));
            check("b_ready", 32'(b_ready), 32'(n <= W));
            if (n > 0) begin
                e = qb.pop_front();
                check("b_data", 32'(b_data), 32'(e[1]));
                check("b_done", 32'(b_done), 32'(e[0]));
            end else begin
                check("b_idle_data", 32'(b_data), 32'd1);
                check("b_idle_done", 32'(b_done), 32'd0);
            end
            if (b_valid && b_ready) push_b(b_word);
        end
    end

    // Callers start just after a rising edge; returns just after the accept edge.
    task automatic send_a(input logic [W-1:0] w);
        int t;
        a_word  = w;
        a_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!a_ready && t < 200);
        if (!a_ready) timeout("a_accept_timeout");
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [W-1:0] w);
        int t;
        b_word  = w;
        b_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!b_ready && t < 200);
        if (!b_ready) timeout("b_accept_timeout");
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 200) timeout("drain_timeout");
        idle(2);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        send_a(8'hE6);
        idle(12);

        send_a(8'hFF);
        send_a(8'h0F);
        send_a(8'h3C);
        drain();

        send_b(8'h01);
        drain();

        send_a(8'hAA);
        send_a(8'h55);
        repeat (2) @(posedge clk);
        #1;
        check("pre_abort_valid", 32'(a_dv), 32'd1);
        reset = 1'b0;
        #1;
        check("async_valid", 32'(a_dv), 32'd0);
        check("async_ready", 32'(a_ready), 32'd1);
        check("async_busy", 32'(a_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(12);
        send_a(8'h80);
        drain();

        send_a(8'hE6);
        send_a(8'hF0);
        drain();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 12));
            send_a(W'($urandom));
        end
        drain();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 12));
            send_b(W'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
